// File: rtl/cart_bus_seq.sv
// cart_bus_seq
//   Brings up the Bandai 2003 cartridge mapper, then serves host accesses to
//   its four bank registers over the cartridge strobe bus.
//
//   Bring-up order after reset release:
//     UNLK_ACK (ADDR=5Ah) -> UNLK_NAK (ADDR=A5h) -> DRAIN (idle bus while the
//     mapper loads its serial boot bitstream) -> four back-to-back register
//     writes to C0h..C3h -> IDLE.
//   Host accesses: IDLE -> SETUP -> STROBE (PULSE_CYC cycles) -> HOLD -> IDLE.
//
// Ports
//   CLK, RST        clock; asynchronous active-high reset
//   REQ, WR, REG    host request (held until ACK), direction, register index
//   WDATA           host write data, captured when the request is accepted
//   ACK             one-cycle completion pulse (HOLD of a host transaction)
//   RDATA           last read result, held until the next read completes
//   BUSY, READY     FSM not in IDLE / init sequence finished
//   CEn,SSn,WEn,OEn cartridge strobes, active low (CEn is never asserted)
//   ADDR            cartridge address bus
//   DQ_O, DQ_OE     split data bus, write side and its enable
//   DQ_I            split data bus, read side
module cart_bus_seq #(
   parameter int unsigned PULSE_CYC  = 2,
   parameter int unsigned DRAIN_CYC  = 18,
   parameter logic [7:0]  INIT_LAO   = 8'hFF,
   parameter logic [7:0]  INIT_RAMB  = 8'hFF,
   parameter logic [7:0]  INIT_ROMB0 = 8'hFF,
   parameter logic [7:0]  INIT_ROMB1 = 8'hFF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ,
   input  logic       WR,
   input  logic [1:0] REG,
   input  logic [7:0] WDATA,
   output logic       ACK,
   output logic [7:0] RDATA,
   output logic       BUSY,
   output logic       READY,
   output logic       CEn,
   output logic       SSn,
   output logic       WEn,
   output logic       OEn,
   output logic [7:0] ADDR,
   output logic [7:0] DQ_O,
   output logic       DQ_OE,
   input  logic [7:0] DQ_I
);

   // ST_BOOT is only occupied while RST is high; it keeps the bus idle during
   // reset so that the first cycle after release is UNLK_ACK.
   localparam logic [2:0] ST_BOOT     = 3'd0;
   localparam logic [2:0] ST_UNLK_ACK = 3'd1;
   localparam logic [2:0] ST_UNLK_NAK = 3'd2;
   localparam logic [2:0] ST_DRAIN    = 3'd3;
   localparam logic [2:0] ST_SETUP    = 3'd4;
   localparam logic [2:0] ST_STROBE   = 3'd5;
   localparam logic [2:0] ST_HOLD     = 3'd6;
   localparam logic [2:0] ST_IDLE     = 3'd7;

   localparam int unsigned MAX_CYC = (DRAIN_CYC > PULSE_CYC) ? DRAIN_CYC : PULSE_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

   localparam logic [7:0] ADDR_IDLE   = 8'hFF;
   localparam logic [7:0] ADDR_UNLK_A = 8'h5A;
   localparam logic [7:0] ADDR_UNLK_B = 8'hA5;

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             in_init;   // SETUP/STROBE/HOLD belong to the init writes
   logic [1:0]       cur_reg;   // register index of the current cycle
   logic             cur_wr;
   logic [7:0]       cur_data;
   logic             ready_q;
   logic [7:0]       rdata_q;

   function automatic logic [7:0] init_value(input logic [1:0] idx);
      logic [7:0] v;
      case (idx)
         2'd0:    v = INIT_LAO;
         2'd1:    v = INIT_RAMB;
         2'd2:    v = INIT_ROMB0;
         default: v = INIT_ROMB1;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_BOOT;
         cnt      <= '0;
         in_init  <= 1'b1;
         cur_reg  <= '0;
         cur_wr   <= 1'b0;
         cur_data <= '0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state)
            ST_BOOT:     state <= ST_UNLK_ACK;
            ST_UNLK_ACK: state <= ST_UNLK_NAK;
            ST_UNLK_NAK: begin
               state <= ST_DRAIN;
               cnt   <= '0;
            end
            ST_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  // Drain complete: start the first init write (C0h).
                  cnt      <= '0;
                  state    <= ST_SETUP;
                  in_init  <= 1'b1;
                  cur_reg  <= 2'd0;
                  cur_wr   <= 1'b1;
                  cur_data <= init_value(2'd0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SETUP: begin
               state <= ST_STROBE;
               cnt   <= '0;
            end
            ST_STROBE: begin
               if (cnt == PULSE_LAST) begin
                  cnt   <= '0;
                  state <= ST_HOLD;
                  // Sample on the last OEn-low cycle, while the mapper still drives.
                  if (!cur_wr) begin
                     rdata_q <= DQ_I;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               if (in_init && (cur_reg != 2'd3)) begin
                  // Init writes run back to back with no idle bus cycle.
                  state    <= ST_SETUP;
                  cur_reg  <= cur_reg + 2'd1;
                  cur_data <= init_value(cur_reg + 2'd1);
               end else begin
                  state <= ST_IDLE;
                  if (in_init) begin
                     in_init <= 1'b0;
                     ready_q <= 1'b1;
                  end
               end
            end
            ST_IDLE: begin
               // Request fields are captured here and held for the whole cycle.
               if (REQ) begin
                  state    <= ST_SETUP;
                  cur_reg  <= REG;
                  cur_wr   <= WR;
                  cur_data <= WDATA;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Bus drive, decoded from the state so reset idles the bus at once
   // ------------------------------------------------------------------
   always_comb begin
      ADDR  = ADDR_IDLE;
      SSn   = 1'b1;
      WEn   = 1'b1;
      OEn   = 1'b1;
      DQ_OE = 1'b0;
      DQ_O  = '0;
      case (state)
         ST_UNLK_ACK: ADDR = ADDR_UNLK_A;
         ST_UNLK_NAK: ADDR = ADDR_UNLK_B;
         ST_SETUP, ST_STROBE, ST_HOLD: begin
            ADDR  = {6'b110000, cur_reg};
            SSn   = 1'b0;
            DQ_OE = cur_wr;
            DQ_O  = cur_wr ? cur_data : 8'h00;
            if (state == ST_STROBE) begin
               WEn = ~cur_wr;
               OEn = cur_wr;
            end
         end
         default: ;
      endcase
   end

   assign CEn   = 1'b1;
   assign ACK   = (state == ST_HOLD) && !in_init;
   assign BUSY  = (state != ST_IDLE);
   assign READY = ready_q;
   assign RDATA = rdata_q;

endmodule

// File: tb/tb_cart_bus_seq.sv
module tb_cart_bus_seq;

   localparam int P0 = 2;
   localparam int D0 = 18;
   localparam int P1 = 1;
   localparam int D1 = 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // default-parameter instance
   logic       req0, wr0;
   logic [1:0] reg0;
   logic [7:0] wdata0, dqi0, rdata0, addr0, dqo0;
   logic       ack0, busy0, ready0, cen0, ssn0, wen0, oen0, dqoe0;

   // short-timing instance
   logic       req1, wr1;
   logic [1:0] reg1;
   logic [7:0] wdata1, dqi1, rdata1, addr1, dqo1;
   logic       ack1, busy1, ready1, cen1, ssn1, wen1, oen1, dqoe1;

   cart_bus_seq #(.PULSE_CYC(P0), .DRAIN_CYC(D0)) u0 (
      .CLK(CLK), .RST(RST), .REQ(req0), .WR(wr0), .REG(reg0), .WDATA(wdata0),
      .ACK(ack0), .RDATA(rdata0), .BUSY(busy0), .READY(ready0),
      .CEn(cen0), .SSn(ssn0), .WEn(wen0), .OEn(oen0), .ADDR(addr0),
      .DQ_O(dqo0), .DQ_OE(dqoe0), .DQ_I(dqi0)
   );

   cart_bus_seq #(.PULSE_CYC(P1), .DRAIN_CYC(D1)) u1 (
      .CLK(CLK), .RST(RST), .REQ(req1), .WR(wr1), .REG(reg1), .WDATA(wdata1),
      .ACK(ack1), .RDATA(rdata1), .BUSY(busy1), .READY(ready1),
      .CEn(cen1), .SSn(ssn1), .WEn(wen1), .OEn(oen1), .ADDR(addr1),
      .DQ_O(dqo1), .DQ_OE(dqoe1), .DQ_I(dqi1)
   );

   assign dqi1 = 8'h96;

   // clock edges since reset release; cycle index at a negedge is edges-1
   int edges = 0;
   always @(posedge CLK or posedge RST)
      if (RST) edges <= 0;
      else     edges <= edges + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- mapper model (RSTn = ~RST) ----------------
   logic [7:0] mreg[4];
   logic       munl;
   logic [7:0] mprev_addr;
   logic       mprev_wen;

   initial forever begin
      @(negedge CLK or posedge RST);
      if (RST) begin
         munl = 1'b0;
         for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
         mprev_addr = 8'hFF;
         mprev_wen  = 1'b1;
      end else begin
         if (mprev_addr == 8'h5A && addr0 == 8'hA5) munl = 1'b1;
         if (munl && !mprev_wen && wen0 && !ssn0 && addr0[7:2] == 6'b110000)
            mreg[addr0[1:0]] = dqo0;
         mprev_addr = addr0;
         mprev_wen  = wen0;
      end
   end

   assign dqi0 = (!ssn0 && !oen0) ? mreg[addr0[1:0]] : 8'hEE;

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic       wr;
      logic [1:0] r;
      logic [7:0] d;
      logic [7:0] rd;
   } txn_t;

   txn_t       expq[$];
   logic [7:0] model[4];
   logic       gap_exact = 1'b0;

   // Expected bus/status vector {ADDR, SSn, WEn, OEn, CEn, DQ_OE, ACK, READY, BUSY}
   // in cycle k after reset release, with no host request served yet.
   function automatic logic [15:0] init_exp(input int k, input int p, input int d);
      int j, ph;
      logic [7:0] a;
      logic we;
      if (k == 0) return {8'h5A, 8'b1111_0001};
      if (k == 1) return {8'hA5, 8'b1111_0001};
      if (k < 2 + d) return {8'hFF, 8'b1111_0001};
      j = k - 2 - d;
      if (j < 4 * (p + 2)) begin
         a  = 8'hC0 + 8'(j / (p + 2));
         ph = j % (p + 2);
         we = (ph >= 1 && ph <= p) ? 1'b0 : 1'b1;
         return {a, 1'b0, we, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      end
      return {8'hFF, 8'b1111_0010};
   endfunction

   // monitor for u0 host transactions
   logic       in_txn = 1'b0;
   int         t_start, t_we, t_oe, t_oe_hi, t_bad, cyc;
   int         last_ack = -10;
   logic [7:0] t_addr;
   logic [7:0] last_rd_exp = 8'h00;
   txn_t       cur;

   initial forever begin
      @(negedge CLK or posedge RST);
      if (RST) begin
         in_txn      = 1'b0;
         last_ack    = -10;
         last_rd_exp = 8'h00;
      end else if (ready0) begin
         cyc = edges - 1;
         if (cyc == last_ack + 1) chk("bus_idle_after_ack", {ssn0, ack0}, 2'b10);
         if (!in_txn && !ssn0) begin
            in_txn  = 1'b1;
            t_start = cyc;
            t_we    = 0;
            t_oe    = 0;
            t_oe_hi = 0;
            t_bad   = 0;
            t_addr  = addr0;
            if (gap_exact) chk("one_idle_gap", cyc - last_ack, 2);
         end
         if (in_txn) begin
            if (!wen0) t_we++;
            if (!oen0) t_oe++;
            if (dqoe0) t_oe_hi++;
            if (ssn0 || addr0 !== t_addr) t_bad++;
            if (ack0) begin
               in_txn   = 1'b0;
               last_ack = cyc;
               chk("ack_has_request", expq.size() > 0, 1'b1);
               if (expq.size() > 0) begin
                  cur = expq.pop_front();
                  chk("txn_addr", t_addr, {6'b110000, cur.r});
                  chk("txn_latency", cyc - t_start, P0 + 1);
                  chk("wen_low_cycles", t_we, cur.wr ? P0 : 0);
                  chk("oen_low_cycles", t_oe, cur.wr ? 0 : P0);
                  chk("dq_oe_cycles", t_oe_hi, cur.wr ? P0 + 2 : 0);
                  chk("addr_ssn_stable", t_bad, 0);
                  chk("hold_strobes", {wen0, oen0, cen0}, 3'b111);
                  if (cur.wr) begin
                     chk("write_dq", dqo0, cur.d);
                     chk("rdata_kept", rdata0, last_rd_exp);
                  end else begin
                     chk("read_data", rdata0, cur.rd);
                     last_rd_exp = cur.rd;
                  end
               end
            end
         end else begin
            chk("no_ack_when_idle", ack0, 1'b0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue0(input logic w, input logic [1:0] r, input logic [7:0] d, input bit keep);
      txn_t e;
      bit   ok, scr;
      e.wr = w;
      e.r  = r;
      e.d  = d;
      e.rd = w ? 8'h00 : model[r];
      if (w) model[r] = d;
      expq.push_back(e);
      wr0 = w; reg0 = r; wdata0 = d; req0 = 1'b1;
      ok = 0; scr = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (!ssn0 && !scr && ready0) begin
            // fields must have been captured; changing them now must not matter
            wr0 = 1'($urandom); reg0 = 2'($urandom); wdata0 = 8'($urandom);
            scr = 1;
         end
         if (ack0) begin ok = 1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL ack_timeout actual=none required=ACK within 60 cycles");
         expq.delete();
      end
      gap_exact = keep;
      if (!keep) req0 = 1'b0;
   endtask

   task automatic fast_txn(input logic w, input logic [1:0] r, input logic [7:0] d);
      int  c;
      bit  ok;
      repeat (2) @(negedge CLK);
      wr1 = w; reg1 = r; wdata1 = d; req1 = 1'b1;
      c  = edges - 1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (ack1) begin ok = 1; break; end
      end
      req1 = 1'b0;
      chk("fast_ack_latency", ok ? (edges - 1 - c) : -1, 3);
      if (!w) chk("fast_read_data", rdata1, 8'h96);
      else    chk("fast_write_dq", {dqoe1, dqo1}, {1'b1, d});
   endtask

   task automatic trace(input int ncyc);
      logic [15:0] e;
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge CLK);
         e = init_exp(k, P0, D0);
         chk("init_bus_u0", {addr0, ssn0, wen0, oen0, cen0, dqoe0, ack0, ready0, busy0}, e);
         if (e[3]) chk("init_dq_u0", dqo0, 8'hFF);
         e = init_exp(k, P1, D1);
         chk("init_bus_u1", {addr1, ssn1, wen1, oen1, cen1, dqoe1, ack1, ready1, busy1}, e);
         if (e[3]) chk("init_dq_u1", dqo1, 8'hFF);
      end
   endtask

   task automatic check_mapper();
      chk("mapper_unlocked", munl, 1'b1);
      for (int unsigned r = 0; r < 4; r++) chk("mapper_reg", mreg[r], model[r]);
   endtask

   initial begin
      bit ok;
      req0 = 0; wr0 = 0; reg0 = 0; wdata0 = 0;
      req1 = 0; wr1 = 0; reg1 = 0; wdata1 = 0;
      for (int i = 0; i < 4; i++) model[i] = 8'hFF;

      repeat (3) @(negedge CLK);
      chk("reset_bus_u0", {addr0, ssn0, wen0, oen0, cen0, dqoe0, ack0, ready0, busy0}, {8'hFF, 8'b1111_0001});
      chk("reset_data_u0", {dqo0, rdata0}, 16'h0000);
      chk("reset_bus_u1", {addr1, ssn1, wen1, oen1, cen1, dqoe1, ack1, ready1, busy1}, {8'hFF, 8'b1111_0001});
      RST = 1'b0;

      // init trace; a request raised during DRAIN must wait for READY
      fork
         trace(36);
         begin
            repeat (6) @(negedge CLK);
            issue0(1'b1, 2'd1, 8'h5B, 1'b0);
         end
      join
      @(negedge CLK);
      check_mapper();

      // directed write then read-back of ROMB0
      issue0(1'b1, 2'd2, 8'h3C, 1'b0);
      issue0(1'b0, 2'd2, 8'h00, 1'b0);
      @(negedge CLK);
      chk("mapper_romb0", mreg[2], 8'h3C);

      // short-timing instance
      fast_txn(1'b1, 2'd3, 8'hA7);
      fast_txn(1'b0, 2'd0, 8'h00);

      // random traffic, REQ sometimes held across transactions
      for (int n = 0; n < 40; n++) begin
         logic w;
         logic [1:0] r;
         logic [7:0] d;
         bit keep;
         w = 1'($urandom); r = 2'($urandom); d = 8'($urandom);
         keep = bit'($urandom_range(0, 1));
         if (!req0) repeat ($urandom_range(0, 3)) @(negedge CLK);
         issue0(w, r, d, keep);
      end
      gap_exact = 1'b0;
      req0 = 1'b0;
      repeat (2) @(negedge CLK);
      check_mapper();

      // reset in the STROBE of a write to C1h
      wr0 = 1'b1; reg0 = 2'd1; wdata0 = 8'h42; req0 = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!wen0) begin ok = 1; break; end
      end
      chk("strobe_reached", ok, 1'b1);
      RST = 1'b1;
      #1;
      chk("midreset_bus", {addr0, ssn0, wen0, oen0, cen0, dqoe0, ack0, ready0, busy0}, {8'hFF, 8'b1111_0001});
      req0 = 1'b0;
      expq.delete();
      for (int i = 0; i < 4; i++) model[i] = 8'hFF;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      trace(36);
      @(negedge CLK);
      check_mapper();
      issue0(1'b0, 2'd1, 8'h00, 1'b0);
      repeat (3) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cart_bus_seq.md
# cart_bus_seq

Cartridge-bus sequencer that brings up the Bandai 2003 mapper and then serves host accesses to its bank registers. After reset it drives the two-address unlock handshake (5Ah, A5h), waits out the mapper's serial boot bitstream, and writes default values into the four bank registers (C0h–C3h). It then arbitrates a single host request port onto the cartridge strobe bus, generating timed SSn/WEn/OEn cycles. It sits between the console-side bus master and the mapper; it never drives a tri-state and uses split DQ.

## Interface
- PULSE_CYC, 2, WEn/OEn low width in CLK cycles (≥1)
- DRAIN_CYC, 18, idle cycles after unlock before first register write (≥1)
- INIT_LAO / INIT_RAMB / INIT_ROMB0 / INIT_ROMB1, 8'hFF each, values written to C0h/C1h/C2h/C3h during init

- CLK  in  1  system clock; all state on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  host request; held high until ACK
- WR  in  1  1 = write, 0 = read; sampled with REQ
- REG  in  2  bank register index (ADDR = C0h + REG)
- WDATA  in  8  write data, sampled with REQ
- ACK  out  1  one-cycle completion pulse
- RDATA  out  8  read data, valid from the ACK cycle until the next read's ACK
- BUSY  out  1  high whenever the FSM is not IDLE
- READY  out  1  high once init is complete; stays high until RST
- CEn, SSn, WEn, OEn  out  1 each  cartridge strobes, active low
- ADDR  out  8  cartridge address bus
- DQ_O  out  8  write data to cartridge
- DQ_OE  out  1  high = DQ_O drives the bus
- DQ_I  in  8  read data from cartridge

## Operation
- CEn is held high at all times; the block only issues SSn (I/O) cycles.
- Idle bus: ADDR=FFh, SSn=WEn=OEn=1, DQ_OE=0.
- States: UNLK_ACK → UNLK_NAK → DRAIN → INIT (SETUP/STROBE/HOLD ×4) → IDLE ⇄ SETUP → STROBE → HOLD.
- UNLK_ACK: one cycle, ADDR=5Ah. UNLK_NAK: one cycle, ADDR=A5h. Strobes stay inactive in both.
- DRAIN: DRAIN_CYC cycles with an idle bus.
- INIT: four write cycles to C0h, C1h, C2h, C3h in order, using INIT_* data, with no idle cycle between them. READY rises in the first IDLE cycle.
- Write cycle:
  - SETUP (1 cycle): ADDR=C0h+REG, SSn=0, DQ_OE=1, DQ_O=data.
  - STROBE (PULSE_CYC cycles): as SETUP, plus WEn=0.
  - HOLD (1 cycle): WEn=1; ADDR, DQ_O and SSn are held, so the mapper latches on the WEn rising edge.
- Read cycle: same sequence with DQ_OE=0 and OEn=0 during STROBE. DQ_I is registered into RDATA on the last STROBE cycle.
- ACK is high during HOLD. The next state is always IDLE, so there is at least one idle bus cycle between transactions.
- REQ is sampled only in IDLE. Requests during init or an active transaction are not queued; the host keeps REQ high. If REQ is still high in the IDLE cycle after ACK, a new transaction starts.
- REG, WR and WDATA are captured in IDLE on acceptance. Later changes have no effect on that transaction.

## Timing
- Reset values (asynchronous, immediate):
  - CEn=SSn=WEn=OEn=1, ADDR=FFh, DQ_OE=0, DQ_O=00h
  - ACK=0, RDATA=00h, BUSY=1, READY=0
- First cycle after RST deasserts is UNLK_ACK.
- Init length: 2 + DRAIN_CYC + 4·(PULSE_CYC+2) cycles. With defaults, READY rises 36 cycles after reset release.
- Transaction latency: REQ accepted in IDLE cycle c → ACK in cycle c+PULSE_CYC+2 → IDLE at c+PULSE_CYC+3.
- Reset mid-transaction: the bus returns to idle immediately, with no WEn rising edge generated by the block. After release, the full unlock/init sequence repeats. The mapper's RSTn is tied to ~RST so both restart together.
- A counter rolls from PULSE_CYC-1 to 0 and then exits STROBE. The DRAIN counter behaves the same way with DRAIN_CYC-1.

## Test plan
- Reset release, defaults: ADDR=5Ah, then A5h, then FFh for 18 cycles; then four writes to C0h–C3h with DQ_O=FFh and a 2-cycle WEn low each; READY=1 at cycle 36. A mapper model then reports unlocked with bank regs FFh.
- Idle write, REG=2, WDATA=3Ch, REQ in cycle c: SSn=0 for cycles c+1..c+4, WEn=0 for c+2..c+3, ADDR=C2h, ACK in c+4; mapper ROMB0=3Ch.
- Read back REG=2: OEn=0 for 2 cycles, DQ_OE=0 throughout, RDATA=3Ch at ACK, ACK pulses exactly once.
- REQ held high continuously with alternating WR: each transaction separated by exactly one idle cycle; REQ raised during DRAIN produces no bus activity until READY.
- RST asserted in the STROBE of a write to C1h: strobes high and DQ_OE=0 in the same cycle, no ACK, BUSY=1. After release the unlock sequence restarts from 5Ah.
- PULSE_CYC=1, DRAIN_CYC=1: READY at cycle 15; ACK at c+3.
